// File: rtl/seq_decoder_pkg.sv
// Shared definitions for the sequential-scrambler receive path.
//   buf_state_t : occupancy of the two-entry output word buffer
//   Q_RESET     : mirror state the sender and receiver both start from
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam logic [1:0] Q_RESET = 2'b00;

endpackage

// File: rtl/seq_bit_decoder.sv
// Bit-level descrambler: keeps a mirror of the sender's 2-bit state and
// recovers one X bit per accepted Y bit.
// Ports:
//   clk       clock
//   CLR       asynchronous active-low reset
//   Y         serial line bit
//   in_valid  Y carries a new bit this cycle
//   x_next    combinational recovered bit for the current Y (feeds word assembly)
//   X         registered recovered bit
//   X_valid   one-cycle pulse when X was updated
//   Q         mirror state {Q1,Q0}
module seq_bit_decoder
  import seq_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       CLR,
  input  logic       Y,
  input  logic       in_valid,
  output logic       x_next,
  output logic       X,
  output logic       X_valid,
  output logic [1:0] Q
);

  assign x_next = Y ^ Q[1] ^ Q[0];

  // Q0 tracks the inverted line bit, so the mirror stays in step with the
  // sender without needing the recovered bit.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      Q       <= Q_RESET;
      X       <= 1'b0;
      X_valid <= 1'b0;
    end else begin
      X_valid <= in_valid;
      if (in_valid) begin
        X <= x_next;
        Q <= {Q[0], ~Y};
      end
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// Receive end of the 2-bit sequential scrambler link. Decodes the serial Y
// stream, packs recovered bits into WIDTH-bit words and offers them through
// a two-entry buffer with a valid/ready handshake.
// Parameters:
//   WIDTH      bits per output word (2..32)
//   MSB_FIRST  0: first received bit lands in out_data[0]; 1: in out_data[WIDTH-1]
// Ports:
//   clk, CLR (async active-low reset), Y, in_valid  : serial input side
//   X, X_valid, Q                                   : per-bit decode outputs
//   out_data, out_valid, out_ready                  : word output handshake
//   overflow                                        : sticky word-dropped flag
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             Y,
  input  logic             in_valid,
  output logic             X,
  output logic             X_valid,
  output logic [1:0]       Q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             x_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic             word_done;
  logic             pop;
  buf_state_t       state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  seq_bit_decoder u_bit (
    .clk      (clk),
    .CLR      (CLR),
    .Y        (Y),
    .in_valid (in_valid),
    .x_next   (x_next),
    .X        (X),
    .X_valid  (X_valid),
    .Q        (Q)
  );

  // The word is formed from the combinational bit so a completed word can
  // enter the buffer on the same edge as its last bit.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next = {shreg[WIDTH-2:0], x_next};
    end else begin : g_lsb
      assign word_next = {x_next, shreg[WIDTH-1:1]};
    end
  endgenerate

  assign word_done = in_valid && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (in_valid) begin
      shreg <= word_next;
      cnt   <= word_done ? '0 : cnt + 1'b1;
    end
  end

  // out_valid is low in EMPTY, so out_ready has no effect there.
  assign pop      = out_valid && out_ready;
  assign out_data = head;

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state     <= EMPTY;
      head      <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (word_done) begin
            head      <= word_next;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (pop && word_done) begin
            head <= word_next;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (word_done) begin
            tail  <= word_next;
            state <= FULL;
          end
        end
        FULL: begin
          if (pop) begin
            head <= tail;
            if (word_done) begin
              tail <= word_next;
            end else begin
              state <= ONE;
            end
          end else if (word_done) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
module tb_seq_decoder;

  logic       clk = 1'b0;
  logic       CLR;
  logic       Y;
  logic       in_valid;
  logic       X;
  logic       X_valid;
  logic [1:0] Q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of words expected at the output, in order.
  logic [7:0] exp_q[$];
  bit         mon_en  = 1'b0;
  bit         push_en = 1'b1;

  // Reference sender state and word-assembly model.
  logic [1:0] s;
  logic [7:0] part;
  int         bcnt;

  seq_decoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk       (clk),
    .CLR       (CLR),
    .Y         (Y),
    .in_valid  (in_valid),
    .X         (X),
    .X_valid   (X_valid),
    .Q         (Q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Words are checked when the handshake completes on the following edge.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL word_pop: got unexpected word %h, scoreboard empty", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures = failures + 1;
          $display("FAIL word_pop: out_data=%h expected=%h", out_data, e);
        end
      end
    end
  end

  task automatic model_reset();
    s    = 2'b00;
    part = 8'h00;
    bcnt = 0;
    exp_q.delete();
  endtask

  // Drive one bit and check the decoded bit and mirror state after the edge.
  task automatic drive_bit(input logic y, input logic exp_x, input logic [1:0] exp_qs);
    Y = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    part = {exp_x, part[7:1]};
    bcnt = bcnt + 1;
    if (bcnt == 8) begin
      bcnt = 0;
      if (push_en) exp_q.push_back(part);
    end
    checks = checks + 1;
    if (X !== exp_x || X_valid !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL bit_x: X=%b X_valid=%b expected X=%b X_valid=1", X, X_valid, exp_x);
    end
    checks = checks + 1;
    if (Q !== exp_qs) begin
      failures = failures + 1;
      $display("FAIL bit_q: Q=%b expected=%b", Q, exp_qs);
    end
  endtask

  // Encode x with the reference sender and push the line bit through the DUT.
  task automatic send_x(input logic x);
    logic y;
    y = x ^ s[1] ^ s[0];
    s = {s[0], ~y};
    drive_bit(y, x, s);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_x(w[i]);
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    Y = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if ({X, X_valid, Q, out_data, out_valid, overflow} !== 14'd0) begin
      failures = failures + 1;
      $display("FAIL reset: X=%b Xv=%b Q=%b data=%h ov=%b of=%b expected all 0",
               X, X_valid, Q, out_data, out_valid, overflow);
    end
    CLR = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_ones();
    for (int i = 0; i < 8; i++) begin
      drive_bit(1'b1, 1'b1, 2'b00);
      if (i == 6) begin
        checks = checks + 1;
        if (out_valid !== 1'b0) begin
          failures = failures + 1;
          $display("FAIL ones_early_valid: out_valid=%b expected 0", out_valid);
        end
      end
    end
    checks = checks + 1;
    if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
      failures = failures + 1;
      $display("FAIL ones_word: out_valid=%b out_data=%h expected 1/ff", out_valid, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zeros();
    logic [7:0] ys;
    logic [1:0] qs[8];
    ys = 8'b1011_0110;
    qs = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 8; i++) drive_bit(ys[i], 1'b0, qs[i]);
    s = 2'b10;
    checks = checks + 1;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      failures = failures + 1;
      $display("FAIL zeros_word: out_valid=%b out_data=%h expected 1/00", out_valid, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_loopback();
    out_ready = 1'b1;
    send_word(8'hA5);
    send_word(8'h3C);
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL loopback: pending=%0d overflow=%b out_valid=%b expected 0/0/0",
               exp_q.size(), overflow, out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    send_word(8'hC3);
    send_word(8'h96);
    push_en = 1'b0;
    send_word(8'h7E);
    push_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hC3) begin
      failures = failures + 1;
      $display("FAIL overflow_hold: overflow=%b out_valid=%b out_data=%h expected 1/1/c3",
               overflow, out_valid, out_data);
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overflow_drain: pending=%0d out_valid=%b overflow=%b expected 0/0/1",
               exp_q.size(), out_valid, overflow);
    end
  endtask

  task automatic test_gaps();
    logic [2:0] ys;
    logic [1:0] qs[3];
    CLR = 1'b0;
    #2;
    CLR = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    ys = 3'b110;
    qs = '{2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 3; i++) begin
      drive_bit(ys[i], 1'b0, qs[i]);
      Y = ~ys[i];
      repeat (2) @(posedge clk);
      #1;
      checks = checks + 1;
      if (X !== 1'b0 || X_valid !== 1'b0 || Q !== qs[i]) begin
        failures = failures + 1;
        $display("FAIL gap_hold: X=%b X_valid=%b Q=%b expected 0/0/%b", X, X_valid, Q, qs[i]);
      end
    end
    s = 2'b00;
  endtask

  task automatic test_clr();
    send_x(1'b1);
    send_x(1'b0);
    @(posedge clk);
    #1;
    CLR = 1'b0;
    #2;
    checks = checks + 1;
    if ({X, X_valid, Q, out_data, out_valid, overflow} !== 14'd0) begin
      failures = failures + 1;
      $display("FAIL clr_async: X=%b Xv=%b Q=%b data=%h ov=%b of=%b expected all 0",
               X, X_valid, Q, out_data, out_valid, overflow);
    end
    CLR = 1'b1;
    model_reset();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    send_word(8'h5A);
    checks = checks + 1;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || overflow !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL clr_fresh_word: out_valid=%b out_data=%h overflow=%b expected 1/5a/0",
               out_valid, out_data, overflow);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL clr_drain: pending=%0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_zeros();
    test_loopback();
    test_overflow();
    test_gaps();
    test_clr();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
